if_fetch_stage: RTL

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

---
 rtl/if_fetch_stage.sv | 100 ++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: loadable instruction memory, PC register and the IF/ID pipeline register.
// The program is streamed in under LoadInstructions; fetch runs from index 0 once loading stops.
module if_fetch_stage #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          LoadInstructions,
  input  logic [31:0]   Instruction,
  input  logic          Stall,
  input  logic          Flush,
  input  logic          PCSrc,
  input  logic [31:0]   BranchTarget,
  output logic [31:0]   PC,
  output logic [31:0]   IF_ID_Instr,
  output logic [31:0]   IF_ID_PCPlus4,
  output logic [AW:0]   ProgLen,
  output logic          LoadOverflow
);

  logic [31:0] r_mem [DEPTH];
  logic [AW:0] r_prog_len;
  logic [AW:0] r_load_ptr;
  logic        r_load_prev;
  logic        r_overflow;
  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;

  logic [AW:0]   w_ptr;
  logic          w_load_wr;
  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic [31:0]   w_fetch;
  logic [31:0]   w_pc_plus4;
  logic          w_unused_bt;

  // A rising LoadInstructions restarts the sequence at index 0 in the same cycle.
  assign w_ptr      = (LoadInstructions && !r_load_prev) ? '0 : r_load_ptr;
  assign w_load_wr  = LoadInstructions && Reset && !w_ptr[AW];
  assign w_idx      = r_pc[AW+1:2];
  assign w_in_range = (r_pc[31:AW+2] == '0) && ({1'b0, w_idx} < r_prog_len);
  assign w_fetch    = w_in_range ? r_mem[w_idx] : 32'h0;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_unused_bt = ^BranchTarget[1:0];

  // Program storage and its length survive reset so a loaded program can be re-run.
  always_ff @(posedge clk) begin
    if (w_load_wr) begin
      r_mem[w_ptr[AW-1:0]] <= Instruction;
      r_prog_len           <= w_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_load_ptr  <= '0;
      r_load_prev <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_load_prev <= LoadInstructions;
      if (LoadInstructions) begin
        if (w_ptr[AW]) r_overflow <= 1'b1;
        else           r_load_ptr <= w_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_pc         <= '0;
      r_ifid_instr <= '0;
      r_ifid_pc4   <= '0;
    end else if (LoadInstructions) begin
      r_pc         <= '0;
      r_ifid_instr <= '0;
      r_ifid_pc4   <= '0;
    end else begin
      // A redirect moves the PC even while the hazard unit holds the IF/ID register.
      if (PCSrc)       r_pc <= {BranchTarget[31:2], 2'b00};
      else if (!Stall) r_pc <= w_pc_plus4;

      if (Flush) begin
        r_ifid_instr <= '0;
        r_ifid_pc4   <= '0;
      end else if (!Stall) begin
        r_ifid_instr <= w_fetch;
        r_ifid_pc4   <= w_pc_plus4;
      end
    end
  end

  assign PC            = r_pc;
  assign IF_ID_Instr   = r_ifid_instr;
  assign IF_ID_PCPlus4 = r_ifid_pc4;
  assign ProgLen       = r_prog_len;
  assign LoadOverflow  = r_overflow;

endmodule
